// File: rtl/msdap_coeff_loader.sv
// msdap_coeff_loader: pairs ROM bytes (high byte first) into 16-bit words.
// The first N_RJ words go to the rj memory and the next N_COEFF words go to
// the coefficient memory. When the load is complete, done is raised.
// Optional macro RJ_SUM_CHECK_EN: adds an rj-sum sanity check (rj_sum_err).
module msdap_coeff_loader #(
   parameter int N_RJ    = 16,
   parameter int N_COEFF = 512
) (
   input  logic                       clk,
   input  logic                       rst_n,
   input  logic                       start,
   input  logic [7:0]                 byte_in,
   input  logic                       byte_valid,
   output logic                       rj_we,
   output logic [$clog2(N_RJ)-1:0]    rj_addr,
   output logic [15:0]                rj_data,
   output logic                       co_we,
   output logic [$clog2(N_COEFF)-1:0] co_addr,
   output logic [15:0]                co_data,
   output logic                       busy,
   output logic                       done,
   output logic                       fmt_err,
   output logic                       rj_sum_err
);

   localparam int RJW = $clog2(N_RJ);
   localparam int COW = $clog2(N_COEFF);
   localparam logic [RJW-1:0] RJ_LAST = RJW'(N_RJ - 1);
   localparam logic [COW-1:0] CO_LAST = COW'(N_COEFF - 1);

   typedef enum logic [1:0] {IDLE, LOAD_RJ, LOAD_CO, DONE} state_t;

   state_t          state;
   logic            phase;     // 0: expecting high byte, 1: expecting low byte
   logic [7:0]      hi;
   logic [RJW-1:0]  rj_cnt;
   logic [COW-1:0]  co_cnt;
   logic [15:0]     word;

   assign word = {hi, byte_in};

`ifdef RJ_SUM_CHECK_EN
   logic [10:0] acc;

   // Sum the low 10 bits of each rj word; compare the sum on entry to DONE.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         acc        <= '0;
         rj_sum_err <= 1'b0;
      end else if ((state == IDLE || state == DONE) && start) begin
         acc        <= '0;
         rj_sum_err <= 1'b0;
      end else if (state == LOAD_RJ && byte_valid && phase) begin
         acc <= acc + {1'b0, word[9:0]};
      end else if (state == LOAD_CO && byte_valid && phase && co_cnt == CO_LAST) begin
         rj_sum_err <= (acc != 11'(N_COEFF));
      end
   end
`else
   assign rj_sum_err = 1'b0;
`endif

   // Load FSM: byte pairing, registered write strobes, address counting, status.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state   <= IDLE;
         phase   <= 1'b0;
         hi      <= '0;
         rj_cnt  <= '0;
         co_cnt  <= '0;
         rj_we   <= 1'b0;
         rj_addr <= '0;
         rj_data <= '0;
         co_we   <= 1'b0;
         co_addr <= '0;
         co_data <= '0;
         busy    <= 1'b0;
         done    <= 1'b0;
         fmt_err <= 1'b0;
      end else begin
         rj_we <= 1'b0;
         co_we <= 1'b0;
         case (state)
            IDLE, DONE: begin
               // Bytes here are dropped; only start matters.
               if (start) begin
                  state   <= LOAD_RJ;
                  busy    <= 1'b1;
                  done    <= 1'b0;
                  fmt_err <= 1'b0;
                  phase   <= 1'b0;
                  rj_cnt  <= '0;
                  co_cnt  <= '0;
               end
            end
            LOAD_RJ: begin
               if (byte_valid) begin
                  if (!phase) begin
                     hi    <= byte_in;
                     phase <= 1'b1;
                  end else begin
                     phase   <= 1'b0;
                     rj_we   <= 1'b1;
                     rj_addr <= rj_cnt;
                     rj_data <= word;
                     // Terminal count switches state instead of wrapping.
                     if (rj_cnt == RJ_LAST) state <= LOAD_CO;
                     else                   rj_cnt <= rj_cnt + 1'b1;
                  end
               end
            end
            LOAD_CO: begin
               if (byte_valid) begin
                  if (!phase) begin
                     hi    <= byte_in;
                     phase <= 1'b1;
                  end else begin
                     phase   <= 1'b0;
                     co_we   <= 1'b1;
                     co_addr <= co_cnt;
                     co_data <= word;
                     // Bits 15:9 must be zero; flag but still write.
                     if (|hi[7:1]) fmt_err <= 1'b1;
                     if (co_cnt == CO_LAST) begin
                        state <= DONE;
                        busy  <= 1'b0;
                        done  <= 1'b1;
                     end else begin
                        co_cnt <= co_cnt + 1'b1;
                     end
                  end
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: doc/msdap_coeff_loader.md
Name: msdap_coeff_loader

Overview:
- Downstream consumer of the byte-wide coefficient ROM in the MSDAP datapath.
- Pairs ROM bytes into 16-bit words, high byte first.
- Writes the first N_RJ words into the rj memory and the next N_COEFF words into the coefficient memory.
- Signals completion to the MSDAP control FSM, then holds idle until the next start.

Parameters:
- N_RJ, 16, number of rj words; rj_addr width = clog2(N_RJ).
- N_COEFF, 512, number of coefficient words; co_addr width = clog2(N_COEFF).

Ports:
- clk  input  1  system clock, all state on rising edge.
- rst_n  input  1  asynchronous active-low reset.
- start  input  1  single-cycle load request.
- byte_in  input  8  ROM data byte.
- byte_valid  input  1  byte_in is valid this cycle.
- rj_we  output  1  rj memory write strobe.
- rj_addr  output  clog2(N_RJ)  rj write address.
- rj_data  output  16  rj write data.
- co_we  output  1  coefficient memory write strobe.
- co_addr  output  clog2(N_COEFF)  coefficient write address.
- co_data  output  16  coefficient write data.
- busy  output  1  load in progress.
- done  output  1  load complete; sticky.
- fmt_err  output  1  malformed coefficient seen; sticky.
- rj_sum_err  output  1  only with RJ_SUM_CHECK_EN; otherwise 0.

Behaviour:
- Reset values: every output 0; FSM in IDLE; byte phase = high; word counters = 0; accumulators = 0.
- Reset is asynchronous at any time, including mid-load. No partial state is retained, and memory contents are undefined afterwards.
- FSM states: IDLE, LOAD_RJ, LOAD_CO, DONE.
- IDLE/DONE -> LOAD_RJ on start=1. This transition:
  - clears done, fmt_err, rj_sum_err, counters and byte phase;
  - sets busy=1 in the following cycle.
- start while in LOAD_RJ or LOAD_CO is ignored.
- Byte pairing (LOAD states only):
  - The first valid byte latches into the high register and toggles phase.
  - The second valid byte forms word = {hi, byte_in}.
  - byte_valid=0 stalls the pairing and may last any number of cycles; phase is held.
  - Bytes arriving in IDLE or DONE are discarded.
- Write timing:
  - The write strobe is registered and asserted exactly 1 cycle after the cycle the low byte is accepted.
  - The strobe is high for 1 cycle; addr/data are valid in the same cycle.
  - rj_we and co_we are never high together.
- LOAD_RJ:
  - rj_addr starts at 0 and increments after each write.
  - After write N_RJ-1 is issued, the FSM moves to LOAD_CO.
  - A byte arriving in the same cycle as that transition is accepted as the first coefficient high byte.
- LOAD_CO:
  - co_addr starts at 0.
  - After write N_COEFF-1 the FSM moves to DONE, with busy=0 and done=1 on the same edge as the last co_we rise.
- Coefficient format:
  - bit8 = sign, bits7:0 = magnitude, bits15:9 must be 0.
  - If any of bits15:9 is nonzero, fmt_err is set the cycle co_we is asserted, and the write still happens.
  - No format check is applied to rj words.
- Address counters never wrap within one load; the terminal count forces the state change.
- DONE holds all outputs until start or reset. A new start from DONE restarts at address 0.

Optional Feature:
- Macro: RJ_SUM_CHECK_EN.
- With the macro defined:
  - An 11-bit accumulator sums the rj words, using the low 10 bits of each.
  - On entry to DONE, rj_sum_err=1 if sum != N_COEFF; it is sticky until the next start.
- Without the macro: no accumulator; rj_sum_err tied to 0.

Test Plan:
- Nominal load: reset, start, then 1056 back-to-back bytes (16 rj words 0x0020, 512 coefficients such as 0x00BF, 0x015A, ...).
  -> 16 rj_we pulses with rj_data=0x0020 at addr 0..15.
  -> 512 co_we pulses: addr0=0x00BF, addr1=0x015A, addr511 as sent.
  -> done=1 the cycle co_we addr 511 fires; fmt_err=0.
- Gapped input: byte_valid toggles 1,0,0,1 repeatedly.
  -> identical write sequence and data as the nominal load, only stretched in time; no spurious strobes.
- Format error: coefficient 37 sent as 0x020F.
  -> co_data=0x020F written at addr 36; fmt_err=1 from that cycle through DONE.
  -> a following start clears fmt_err.
- Reset mid-load: deassert rst_n after 300 bytes.
  -> all outputs 0 immediately.
  -> after a new start, the first write is rj_addr=0 with correct data.
- Start ignored while busy: pulse start at byte 100.
  -> no restart; addresses continue monotonically; done after 1056 bytes total.
- RJ_SUM_CHECK_EN build: load rj[5]=0x0021, others 0x0020 (sum 513).
  -> rj_sum_err=1 at DONE.
  -> with all 0x0020, rj_sum_err=0.
